uart_dec_msg_tx: RTL

Parametrised successor to the fixed 3-digit cycle-count sender. Snapshots a DATA_W-bit value and converts it to decimal with an iterative double-dabble converter. Streams "<prefix>[sign]digits<suffix>[CR LF]" one byte at a time to the shared byte-wide UART transmitter. Generalises width, digit count and framing characters, and adds zero-suppression, overflow saturation and a clean edge-triggered start/done handshake.

---
 rtl/uart_fmt_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 60 ++++++
 rtl/uart_dec_msg_tx.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/uart_fmt_pkg.sv
// rtl/uart_fmt_pkg.sv - shared ASCII constants, sequencer states and BCD sizing for the decimal message sender
package uart_fmt_pkg;

    localparam logic [7:0] CH_LT    = 8'h3C;
    localparam logic [7:0] CH_GT    = 8'h3E;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_ZERO  = 8'h30;
    localparam logic [7:0] CH_MINUS = 8'h2D;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_SEND  = 3'd2,
        ST_GUARD = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Decimal digits needed for 2^width-1: floor(width*log10(2))+1, in integer arithmetic.
    function automatic int bcd_digits(input int width);
        return (width * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - iterative double-dabble converter, one input bit per cycle, DATA_W-cycle latency
module bin2bcd_seq
    import uart_fmt_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load_i,
    input  logic [DATA_W-1:0]                   value_i,
    output logic                                done_o,
    output logic [4*bcd_digits(DATA_W)-1:0]     bcd_o
);

    localparam int DFULL = bcd_digits(DATA_W);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [4*DFULL-1:0] bcd_q, bcd_d;
    logic [4*DFULL-1:0] adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DFULL; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (load_i) begin
            bin_d = value_i;
            bcd_d = '0;
            cnt_d = CNT_W'(DATA_W);
        end else if (cnt_q != '0) begin
            bcd_d = {adj[4*DFULL-2:0], bin_q[DATA_W-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    // High during the cycle whose closing edge performs the final shift.
    assign done_o = (cnt_q == CNT_W'(1));
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/uart_dec_msg_tx.sv
// rtl/uart_dec_msg_tx.sv - decimal message sender to a byte UART; UART_DEC_MSG_TX_SIGNED_EN adds signed input
module uart_dec_msg_tx
    import uart_fmt_pkg::*;
#(
    parameter int         DATA_W      = 16,
    parameter int         NUM_DIGITS  = 5,
    parameter logic [7:0] PREFIX_CHAR = CH_LT,
    parameter logic [7:0] SUFFIX_CHAR = CH_GT,
    parameter bit         EOL_EN      = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    input  logic              zero_pad,
`ifdef UART_DEC_MSG_TX_SIGNED_EN
    input  logic              is_signed,
`endif
    output logic              uart_tx_en,
    output logic [7:0]        uart_tx_data,
    input  logic              uart_tx_busy,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int DFULL = bcd_digits(DATA_W);
    localparam int MAXD  = (NUM_DIGITS > DFULL) ? NUM_DIGITS : DFULL;
    localparam int NSEQ  = NUM_DIGITS + 5;
    localparam int POS_W = $clog2(NSEQ + 1);

    state_e             state_q, state_d;
    logic               start_q;
    logic               zpad_q, zpad_d;
    logic               neg_q, neg_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic               en_q, en_d;
    logic [7:0]         data_q, data_d;
    logic               ovf_q, ovf_d;

    logic               accept;
    logic               neg_in;
    logic [DATA_W-1:0]  conv_in;
    logic               conv_done;
    logic [4*DFULL-1:0] bcd;
    logic [4*MAXD-1:0]  bcd_pad;
    logic [3:0]         dig [NUM_DIGITS];
    logic               ovf;
    logic [NSEQ-1:0]    pos_en;
    logic               seen;
    logic [POS_W-1:0]   cur;
    logic [7:0]         cur_byte;

    assign accept = (state_q == ST_IDLE) && start && !start_q;

`ifdef UART_DEC_MSG_TX_SIGNED_EN
    // The most negative value negates to itself, which is the right magnitude read unsigned.
    assign neg_in  = is_signed & value[DATA_W-1];
    assign conv_in = neg_in ? (~value + DATA_W'(1)) : value;
`else
    assign neg_in  = 1'b0;
    assign conv_in = value;
`endif

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .value_i (conv_in),
        .done_o  (conv_done),
        .bcd_o   (bcd)
    );

    assign bcd_pad = (4*MAXD)'(bcd);

    always_comb begin
        ovf = 1'b0;
        for (int i = NUM_DIGITS; i < MAXD; i++) begin
            if (bcd_pad[4*i +: 4] != 4'd0) ovf = 1'b1;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig[i] = ovf ? 4'd9 : bcd_pad[4*i +: 4];
        end
    end

    // Position map: 0 prefix, 1 sign, 2.. digits (most significant first), then suffix, CR, LF.
    always_comb begin
        pos_en    = '0;
        pos_en[0] = (PREFIX_CHAR != 8'h00);
        pos_en[1] = neg_q;
        seen      = zpad_q;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if ((dig[NUM_DIGITS-1-j] != 4'd0) || (j == NUM_DIGITS-1)) seen = 1'b1;
            pos_en[2+j] = seen;
        end
        pos_en[NUM_DIGITS+2] = (SUFFIX_CHAR != 8'h00);
        pos_en[NUM_DIGITS+3] = EOL_EN;
        pos_en[NUM_DIGITS+4] = EOL_EN;
    end

    always_comb begin
        cur = POS_W'(NSEQ);
        for (int p = NSEQ-1; p >= 0; p--) begin
            if (pos_en[p] && (POS_W'(p) >= pos_q)) cur = POS_W'(p);
        end
    end

    always_comb begin
        cur_byte = CH_LF;
        if (cur == POS_W'(0)) cur_byte = PREFIX_CHAR;
        if (cur == POS_W'(1)) cur_byte = CH_MINUS;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (cur == POS_W'(2+j)) cur_byte = CH_ZERO + {4'h0, dig[NUM_DIGITS-1-j]};
        end
        if (cur == POS_W'(NUM_DIGITS+2)) cur_byte = SUFFIX_CHAR;
        if (cur == POS_W'(NUM_DIGITS+3)) cur_byte = CH_CR;
    end

    always_comb begin
        state_d = state_q;
        zpad_d  = zpad_q;
        neg_d   = neg_q;
        pos_d   = pos_q;
        en_d    = 1'b0;
        data_d  = data_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_CONV;
                    zpad_d  = zero_pad;
                    neg_d   = neg_in;
                    pos_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            ST_CONV: begin
                if (conv_done) state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!uart_tx_busy) begin
                    en_d    = 1'b1;
                    data_d  = cur_byte;
                    pos_d   = cur + POS_W'(1);
                    state_d = ST_GUARD;
                end
            end
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!uart_tx_busy) begin
                    if (cur == POS_W'(NSEQ)) begin
                        state_d = ST_DONE;
                        ovf_d   = ovf;
                    end else begin
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            zpad_q  <= 1'b0;
            neg_q   <= 1'b0;
            pos_q   <= '0;
            en_q    <= 1'b0;
            data_q  <= 8'h00;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            zpad_q  <= zpad_d;
            neg_q   <= neg_d;
            pos_q   <= pos_d;
            en_q    <= en_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
        end
    end

    assign uart_tx_en   = en_q;
    assign uart_tx_data = data_q;
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done         = (state_q == ST_DONE);
    assign overflow     = ovf_q;

endmodule
